// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: main controller for the multicycle RV32I-subset core
// (lw, sw, R-type, I-ALU, beq, jal). One FSM sequences the shared ALU, the
// unified instruction/data memory port and the register file. A watchdog
// abandons a memory access that stalls for MEM_TIMEOUT consecutive cycles.
//
// Optional feature: define MCCTRL_PERF_EN to add the InstRet retired-instruction
// counter output.
//
// Handshake: MemReady is sampled every cycle in FETCH, MEMREAD and MEMWRITE.
// MemReady=1 means the memory completes the access this cycle, so the write
// enables for that access (IRWrite/PCWrite in FETCH, MemWrite in MEMWRITE)
// follow MemReady and the FSM only advances when it is high. There is no
// request valid; the access is implied by the state (visible on state_dbg).

// ALU decoder: maps ALUOp plus instruction fields to the ALU operation.
module aludec (
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] aluop,
    output logic [2:0] alucontrol
);

    // ALUOp 00 = add (addresses, PC+4), 01 = subtract (beq), 10 = by funct3
    always_comb begin
        alucontrol = 3'b000;
        case (aluop)
            2'b00: alucontrol = 3'b000;
            2'b01: alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    // sub only for R-type; addi keeps imm[10] out of the decision
                    3'b000:  alucontrol = (opb5 && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  alucontrol = 3'b101;
                    3'b110:  alucontrol = 3'b011;
                    3'b111:  alucontrol = 3'b010;
                    default: alucontrol = 3'b000;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

endmodule

module multicycle_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  op,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic        RegWrite,
    output logic [2:0]  ALUControl,
    output logic        Illegal,
    output logic        MemTimeout,
`ifdef MCCTRL_PERF_EN
    output logic [31:0] InstRet,
`endif
    output logic [3:0]  state_dbg
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // Counter only needs to reach MEM_TIMEOUT; keep at least one bit.
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_VAL  = CW'(MEM_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam bit WD_EN = (MEM_TIMEOUT != 0);

    state_t          state, state_n;
    logic [CW-1:0]   wait_cnt;
    logic            mem_state;
    logic            timeout;
    logic            illegal_dec;
    logic [1:0]      aluop;
    logic            pcwrite_raw, irwrite_raw, memwrite_raw, regwrite_raw;

    assign state_dbg = state;
    assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
    // A ready access in the same cycle wins over the timeout.
    assign timeout   = WD_EN && mem_state && !MemReady && (wait_cnt == TO_VAL);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    // Watchdog counter: restarts on every state change, counts stalled memory cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if ((state_n != state) || timeout)
            wait_cnt <= '0;
        else if (mem_state && !MemReady && (wait_cnt != CNT_MAX))
            wait_cnt <= wait_cnt + CW'(1);
    end

    // Next-state logic, including illegal-opcode detection in DECODE
    always_comb begin
        state_n     = state;
        illegal_dec = 1'b0;
        case (state)
            S_FETCH:    if (MemReady) state_n = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_n = S_MEMADR;
                    OP_R:         state_n = S_EXECR;
                    OP_I:         state_n = S_EXECI;
                    OP_BEQ:       state_n = S_BEQ;
                    OP_JAL:       state_n = S_JAL;
                    default: begin
                        state_n     = S_FETCH;
                        illegal_dec = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_n = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (MemReady) state_n = S_MEMWB;
            S_MEMWB:    state_n = S_FETCH;
            S_MEMWRITE: if (MemReady) state_n = S_FETCH;
            S_EXECR:    state_n = S_ALUWB;
            S_EXECI:    state_n = S_ALUWB;
            S_ALUWB:    state_n = S_FETCH;
            S_BEQ:      state_n = S_FETCH;
            S_JAL:      state_n = S_ALUWB;
            default:    state_n = S_FETCH;
        endcase
        if (timeout) state_n = S_FETCH;
    end

    // Output decode: Moore from state, except MemReady/Zero qualified enables
    always_comb begin
        pcwrite_raw  = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        AdrSrc       = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        aluop        = 2'b00;
        case (state)
            S_FETCH: begin
                ALUSrcB     = 2'b10;
                ResultSrc   = 2'b10;
                irwrite_raw = MemReady;
                pcwrite_raw = MemReady;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc    = 2'b01;
                regwrite_raw = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc       = 1'b1;
                memwrite_raw = MemReady;
            end
            S_EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
            end
            S_EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA     = 2'b10;
                aluop       = 2'b01;
                pcwrite_raw = Zero;
            end
            S_JAL: begin
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                pcwrite_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Immediate format follows the opcode directly
    always_comb begin
        case (op)
            OP_SW:   ImmSrc = 2'b01;
            OP_BEQ:  ImmSrc = 2'b10;
            OP_JAL:  ImmSrc = 2'b11;
            default: ImmSrc = 2'b00;
        endcase
    end

    // Reset masks every enable and pulse so nothing is written mid-abandon
    assign PCWrite    = pcwrite_raw  && !reset;
    assign IRWrite    = irwrite_raw  && !reset;
    assign MemWrite   = memwrite_raw && !reset;
    assign RegWrite   = regwrite_raw && !reset;
    assign Illegal    = illegal_dec  && !reset;
    assign MemTimeout = timeout      && !reset;

    aludec u_aludec (
        .opb5       (op[5]),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .aluop      (aluop),
        .alucontrol (ALUControl)
    );

`ifdef MCCTRL_PERF_EN
    logic retire;
    // An instruction retires when its final state hands back to FETCH normally
    assign retire = !timeout && (state_n == S_FETCH) &&
                    ((state == S_MEMWB) || (state == S_MEMWRITE) ||
                     (state == S_ALUWB) || (state == S_BEQ));

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       InstRet <= '0;
        else if (retire) InstRet <= InstRet + 32'd1;
    end
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Built with MEM_TIMEOUT=4. The driver walks each
// instruction through the phase sequence the ISA dictates and pushes one
// expected control word per cycle; a negedge monitor pops and compares.
// Define MCCTRL_PERF_EN to also check InstRet.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  localparam int TO = 4;

  localparam logic [3:0] P_FETCH = 4'd0, P_DECODE = 4'd1, P_MEMADR = 4'd2,
                         P_MEMREAD = 4'd3, P_MEMWB = 4'd4, P_MEMWRITE = 4'd5,
                         P_EXECR = 4'd6, P_EXECI = 4'd7, P_ALUWB = 4'd8,
                         P_BEQ = 4'd9, P_JAL = 4'd10;

  localparam int C_LW = 0, C_SW = 1, C_R = 2, C_I = 3, C_BEQ = 4, C_JAL = 5, C_ILL = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal, MemTimeout;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  state_dbg;
`ifdef MCCTRL_PERF_EN
  logic [31:0] InstRet;
`endif

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .Illegal(Illegal), .MemTimeout(MemTimeout),
`ifdef MCCTRL_PERF_EN
    .InstRet(InstRet),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // scoreboard state
  logic [21:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc_idx = 0;
  int          exp_ret = 0;

  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  logic        cur_f7;
  logic        cur_rst;

  // Expected control word for one cycle of a named phase.
  function automatic logic [21:0] exp_word(input logic [3:0] ph, input logic mr,
      input logic z, input logic rst, input logic tmo, input logic [6:0] o,
      input logic [2:0] f3, input logic f7);
    logic pcw, adr, mw, irw, rw, ill;
    logic [1:0] res, sa, sb, aop, imm;
    logic [2:0] alc;
    pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0; ill = 0;
    res = 0; sa = 0; sb = 0; aop = 0;
    case (ph)
      P_FETCH:    begin sb = 2; res = 2; irw = mr; pcw = mr; end
      P_DECODE:   begin sa = 1; sb = 1;
                    ill = !(o inside {7'b0000011, 7'b0100011, 7'b0110011,
                                      7'b0010011, 7'b1100011, 7'b1101111});
                  end
      P_MEMADR:   begin sa = 2; sb = 1; end
      P_MEMREAD:  begin adr = 1; end
      P_MEMWB:    begin res = 1; rw = 1; end
      P_MEMWRITE: begin adr = 1; mw = mr; end
      P_EXECR:    begin sa = 2; aop = 2; end
      P_EXECI:    begin sa = 2; sb = 1; aop = 2; end
      P_ALUWB:    begin rw = 1; end
      P_BEQ:      begin sa = 2; aop = 1; pcw = z; end
      P_JAL:      begin sa = 1; sb = 2; pcw = 1; end
      default: ;
    endcase
    case (o)
      7'b0100011: imm = 1;
      7'b1100011: imm = 2;
      7'b1101111: imm = 3;
      default:    imm = 0;
    endcase
    if (aop == 2'd1) alc = 3'b001;
    else if (aop == 2'd2) begin
      case (f3)
        3'b000:  alc = (o[5] && f7) ? 3'b001 : 3'b000;
        3'b010:  alc = 3'b101;
        3'b110:  alc = 3'b011;
        3'b111:  alc = 3'b010;
        default: alc = 3'b000;
      endcase
    end else alc = 3'b000;
    if (rst) begin pcw = 0; irw = 0; mw = 0; rw = 0; ill = 0; end
    return {ph, pcw, adr, mw, irw, res, sa, sb, imm, rw, alc, ill, tmo && !rst};
  endfunction

  // driver: one cycle of inputs plus its expectation
  task automatic drive(input logic [3:0] ph, input logic mr, input logic z, input logic tmo);
    reset    = cur_rst;
    op       = cur_op;
    funct3   = cur_f3;
    funct7b5 = cur_f7;
    MemReady = mr;
    Zero     = z;
    exp_q.push_back(exp_word(ph, mr, z, cur_rst, tmo, cur_op, cur_f3, cur_f7));
    @(posedge clk);
    #1;
  endtask

  // Memory phase with k stall cycles; stall index TO times out.
  task automatic mem_phase(input logic [3:0] ph, input int k, output bit ok);
    for (int i = 0; i < k && i <= TO; i++)
      drive(ph, 1'b0, 1'($urandom_range(0, 1)), i == TO);
    ok = (k <= TO);
    if (ok) drive(ph, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic set_instr(input int cls);
    logic [6:0] ill_ops[4];
    logic [2:0] f3s[4];
    ill_ops = '{7'b1111111, 7'b0000000, 7'b0110111, 7'b1100111};
    f3s     = '{3'b000, 3'b010, 3'b110, 3'b111};
    case (cls)
      C_LW:    cur_op = 7'b0000011;
      C_SW:    cur_op = 7'b0100011;
      C_R:     cur_op = 7'b0110011;
      C_I:     cur_op = 7'b0010011;
      C_BEQ:   cur_op = 7'b1100011;
      C_JAL:   cur_op = 7'b1101111;
      default: cur_op = ill_ops[$urandom_range(0, 3)];
    endcase
    cur_f3 = f3s[$urandom_range(0, 3)];
    cur_f7 = 1'($urandom_range(0, 1));
  endtask

  task automatic run_instr(input int cls, input int kf, input int km, input logic zb);
    bit ok;
    mem_phase(P_FETCH, kf, ok);
    if (!ok) return;
    drive(P_DECODE, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    case (cls)
      C_LW: begin
        drive(P_MEMADR, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        mem_phase(P_MEMREAD, km, ok);
        if (ok) begin
          drive(P_MEMWB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
          exp_ret++;
        end
      end
      C_SW: begin
        drive(P_MEMADR, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        mem_phase(P_MEMWRITE, km, ok);
        if (ok) exp_ret++;
      end
      C_R, C_I: begin
        drive((cls == C_R) ? P_EXECR : P_EXECI, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
        drive(P_ALUWB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        exp_ret++;
      end
      C_BEQ: begin
        drive(P_BEQ, 1'($urandom_range(0, 1)), zb, 1'b0);
        exp_ret++;
      end
      C_JAL: begin
        drive(P_JAL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        drive(P_ALUWB, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        exp_ret++;
      end
      default: ;
    endcase
  endtask

`ifdef MCCTRL_PERF_EN
  task automatic check_perf();
    checks++;
    if (InstRet !== 32'(exp_ret)) begin
      failures++;
      $display("FAIL inst_ret actual=%0d required=%0d", InstRet, exp_ret);
    end
  endtask
`endif

  // monitor: compares every presented cycle against the queue head
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [21:0] e, a;
      e = exp_q.pop_front();
      a = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
           ALUSrcB, ImmSrc, RegWrite, ALUControl, Illegal, MemTimeout};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_outputs idx=%0d actual=%h required=%h (state act=%0d req=%0d)",
                 cyc_idx, a, e, a[21:18], e[21:18]);
      end
      cyc_idx++;
    end
  end

  // global time bound
  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok;
    reset = 1'b1; op = 0; funct3 = 0; funct7b5 = 0; Zero = 0; MemReady = 0;
    cur_rst = 1'b1; cur_op = 7'b0110011; cur_f3 = 0; cur_f7 = 0;
    @(posedge clk);
    #1;
    // reset state: FETCH, enables held low even with MemReady=1
    drive(P_FETCH, 1'b1, 1'b0, 1'b0);
    drive(P_FETCH, 1'b1, 1'b1, 1'b0);
    cur_rst = 1'b0;
    exp_ret = 0;
`ifdef MCCTRL_PERF_EN
    check_perf();
`endif

    // add, sub, addi with Instr[30]=1
    cur_op = 7'b0110011; cur_f3 = 3'b000; cur_f7 = 1'b0; run_instr(C_R, 0, 0, 1'b0);
    cur_f7 = 1'b1;                                      run_instr(C_R, 0, 0, 1'b0);
    cur_op = 7'b0010011;                                run_instr(C_I, 0, 0, 1'b0);
`ifdef MCCTRL_PERF_EN
    check_perf();
`endif
    // lw with three stall cycles in MEMREAD, then one right at the limit
    cur_op = 7'b0000011; run_instr(C_LW, 0, 3, 1'b0);
    run_instr(C_LW, 0, TO, 1'b0);
    // beq taken and not taken
    cur_op = 7'b1100011; run_instr(C_BEQ, 0, 0, 1'b1);
    run_instr(C_BEQ, 0, 0, 1'b0);
    // illegal opcode
    cur_op = 7'b1111111; run_instr(C_ILL, 0, 0, 1'b0);
    // fetch watchdog, then a clean jal
    cur_op = 7'b1101111; run_instr(C_JAL, TO + 1, 0, 1'b0);
    run_instr(C_JAL, 0, 0, 1'b0);
    // store watchdog
    cur_op = 7'b0100011; run_instr(C_SW, 1, TO + 1, 1'b0);
`ifdef MCCTRL_PERF_EN
    check_perf();
`endif

    // reset while MEMWRITE stalls
    cur_op = 7'b0100011;
    mem_phase(P_FETCH, 0, ok);
    drive(P_DECODE, 1'b1, 1'b0, 1'b0);
    drive(P_MEMADR, 1'b1, 1'b0, 1'b0);
    drive(P_MEMWRITE, 1'b0, 1'b0, 1'b0);
    cur_rst = 1'b1;
    drive(P_FETCH, 1'b0, 1'b0, 1'b0);
    drive(P_FETCH, 1'b1, 1'b0, 1'b0);
    cur_rst = 1'b0;
    exp_ret = 0;
`ifdef MCCTRL_PERF_EN
    check_perf();
`endif

    // randomized instruction stream
    for (int n = 0; n < 80; n++) begin
      int cls, kf, km;
      cls = ($urandom_range(0, 9) == 0) ? C_ILL : int'($urandom_range(0, 5));
      kf  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TO + 1)) : 0;
      km  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, TO + 1)) : 0;
      set_instr(cls);
      run_instr(cls, kf, km, 1'($urandom_range(0, 1)));
    end
`ifdef MCCTRL_PERF_EN
    check_perf();
`endif

    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
